// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// instruction classes, ALU class codes, trap causes and the control-word bundle.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_R     = 3'd1,
        CLS_I     = 3'd2,
        CLS_LOAD  = 3'd3,
        CLS_STORE = 3'd4,
        CLS_BR    = 3'd5,
        CLS_JAL   = 3'd6,
        CLS_JALR  = 3'd7
    } class_t;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_ADD = 2'b01;
    localparam logic [1:0] ALUOP_BR  = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IMEM    = 2'b10;
    localparam logic [1:0] TC_DMEM    = 2'b11;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_write;
        logic       pc_write;
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write_en;
        logic       instr_retired;
        logic       trap;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_mem_class(input class_t c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier; JALR legality is a build-time option.
module opcode_class_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int SUPPORT_JALR = 1
) (
    input  logic [6:0] i_opcode,
    output class_t     o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = CLS_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            OP_R:     o_class = CLS_R;
            OP_I:     o_class = CLS_I;
            OP_LOAD:  o_class = CLS_LOAD;
            OP_STORE: o_class = CLS_STORE;
            OP_BR:    o_class = CLS_BR;
            OP_JAL:   o_class = CLS_JAL;
            OP_JALR: begin
                if (SUPPORT_JALR != 0) begin
                    o_class = CLS_JALR;
                end else begin
                    o_legal = 1'b0;
                end
            end
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with handshaked
// memories, a per-handshake wait timeout and a sticky trap state.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 2,
    parameter int SUPPORT_JALR = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int TO_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                reg_write_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_retired,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
);

    // The wait that would bring the count to MEM_TIMEOUT is the one that traps.
    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next_state;
    class_t          r_class;
    class_t          w_dec_class;
    logic            w_dec_legal;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_next;
    logic [TO_W-1:0] w_cnt_inc;
    logic            w_cnt_hit;
    logic [1:0]      r_cause;
    logic [1:0]      w_cause_next;
    ctrl_t           w_ctrl;

    opcode_class_decoder #(
        .SUPPORT_JALR (SUPPORT_JALR)
    ) u_decoder (
        .i_opcode (opcode),
        .o_class  (w_dec_class),
        .o_legal  (w_dec_legal)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_hit = (r_cnt >= TMO_LAST);

    // Counter only runs while a handshake is pending, so every handshake starts from zero.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = '0;
        w_cause_next = r_cause;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_cnt_hit) begin
                    w_next_state = ST_TRAP;
                    w_cause_next = TC_IMEM;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_DECODE: begin
                if (w_dec_legal) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_TRAP;
                    w_cause_next = TC_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (r_class == CLS_BR) begin
                    w_next_state = ST_FETCH;
                end else if (is_mem_class(r_class)) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    w_next_state = (r_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (w_cnt_hit) begin
                    w_next_state = ST_TRAP;
                    w_cause_next = TC_DMEM;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_WB:   w_next_state = ST_FETCH;
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
            r_cause <= TC_NONE;
            r_class <= CLS_NONE;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_cause <= w_cause_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_dec_class;
            end
        end
    end

    // Control word from state and latched class; held idle while reset is asserted.
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.imem_req = 1'b1;
                w_ctrl.ir_write = imem_ready;
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_R: begin
                        w_ctrl.alu_src = 1'b0;
                        w_ctrl.alu_op  = ALUOP_R;
                    end
                    CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: begin
                        w_ctrl.alu_src = 1'b1;
                        w_ctrl.alu_op  = ALUOP_ADD;
                    end
                    CLS_BR: begin
                        w_ctrl.alu_op        = ALUOP_BR;
                        w_ctrl.branch        = 1'b1;
                        w_ctrl.pc_write      = 1'b1;
                        w_ctrl.instr_retired = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                w_ctrl.dmem_req     = 1'b1;
                w_ctrl.alu_src      = 1'b1;
                w_ctrl.alu_op       = ALUOP_ADD;
                w_ctrl.mem_read_en  = (r_class == CLS_LOAD);
                w_ctrl.mem_write_en = (r_class == CLS_STORE);
                if (dmem_ready && (r_class == CLS_STORE)) begin
                    w_ctrl.pc_write      = 1'b1;
                    w_ctrl.instr_retired = 1'b1;
                end
            end
            ST_WB: begin
                w_ctrl.reg_write_en  = 1'b1;
                w_ctrl.pc_write      = 1'b1;
                w_ctrl.instr_retired = 1'b1;
                w_ctrl.reg_dst       = (r_class == CLS_R) || (r_class == CLS_JAL);
                w_ctrl.mem_to_reg    = (r_class == CLS_LOAD);
                w_ctrl.jump          = (r_class == CLS_JAL) || (r_class == CLS_JALR);
            end
            ST_TRAP: w_ctrl.trap = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            w_ctrl = CTRL_IDLE;
        end
    end

    assign imem_req      = w_ctrl.imem_req;
    assign dmem_req      = w_ctrl.dmem_req;
    assign ir_write      = w_ctrl.ir_write;
    assign pc_write      = w_ctrl.pc_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign jump          = w_ctrl.jump;
    assign branch        = w_ctrl.branch;
    assign mem_read_en   = w_ctrl.mem_read_en;
    assign mem_write_en  = w_ctrl.mem_write_en;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign alu_src       = w_ctrl.alu_src;
    assign reg_write_en  = w_ctrl.reg_write_en;
    assign alu_op        = ALU_OP_W'(w_ctrl.alu_op);
    assign instr_retired = w_ctrl.instr_retired;
    assign trap          = w_ctrl.trap;
    assign trap_cause    = r_cause;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: expected per-cycle control traces are built from the
// instruction-class rules and compared against two DUT builds (JALR on / off).
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    localparam int TMO = 4;

    localparam logic [11:0] C_IREQ = 12'h800;
    localparam logic [11:0] C_DREQ = 12'h400;
    localparam logic [11:0] C_IRW  = 12'h200;
    localparam logic [11:0] C_PCW  = 12'h100;
    localparam logic [11:0] C_RDST = 12'h080;
    localparam logic [11:0] C_JMP  = 12'h040;
    localparam logic [11:0] C_BR   = 12'h020;
    localparam logic [11:0] C_MRD  = 12'h010;
    localparam logic [11:0] C_MWR  = 12'h008;
    localparam logic [11:0] C_M2R  = 12'h004;
    localparam logic [11:0] C_ASRC = 12'h002;
    localparam logic [11:0] C_RWE  = 12'h001;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef struct packed {
        logic        ir;
        logic        dr;
        logic [20:0] exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n_j, rst_n_n;
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready;

    logic       j_ireq, j_dreq, j_irw, j_pcw, j_rdst, j_jmp, j_br, j_mrd, j_mwr, j_m2r, j_asrc, j_rwe, j_ret, j_trap;
    logic [1:0] j_aop, j_cause;
    logic [2:0] j_st;
    logic       n_ireq, n_dreq, n_irw, n_pcw, n_rdst, n_jmp, n_br, n_mrd, n_mwr, n_m2r, n_asrc, n_rwe, n_ret, n_trap;
    logic [1:0] n_aop, n_cause;
    logic [2:0] n_st;
    logic [20:0] obs_j, obs_n;

    int       n_chk = 0;
    int       n_err = 0;
    int       m_ret = 0;
    int       dut_ret = 0;
    logic [1:0] m_cause = 2'd0;
    bit       use_n = 1'b0;
    string    tag = "init";
    step_t    q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_OP_W(2), .SUPPORT_JALR(1), .MEM_TIMEOUT(TMO), .TO_W(3)) u_dut_j (
        .clk(clk), .rst_n(rst_n_j), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(j_ireq), .dmem_req(j_dreq), .ir_write(j_irw), .pc_write(j_pcw), .reg_dst(j_rdst),
        .jump(j_jmp), .branch(j_br), .mem_read_en(j_mrd), .mem_write_en(j_mwr), .mem_to_reg(j_m2r),
        .alu_src(j_asrc), .reg_write_en(j_rwe), .alu_op(j_aop), .instr_retired(j_ret), .trap(j_trap),
        .trap_cause(j_cause), .state(j_st));

    multicycle_control_unit #(.ALU_OP_W(2), .SUPPORT_JALR(0), .MEM_TIMEOUT(TMO), .TO_W(3)) u_dut_n (
        .clk(clk), .rst_n(rst_n_n), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(n_ireq), .dmem_req(n_dreq), .ir_write(n_irw), .pc_write(n_pcw), .reg_dst(n_rdst),
        .jump(n_jmp), .branch(n_br), .mem_read_en(n_mrd), .mem_write_en(n_mwr), .mem_to_reg(n_m2r),
        .alu_src(n_asrc), .reg_write_en(n_rwe), .alu_op(n_aop), .instr_retired(n_ret), .trap(n_trap),
        .trap_cause(n_cause), .state(n_st));

    assign obs_j = {j_st, j_cause, j_trap, j_ireq, j_dreq, j_irw, j_pcw, j_rdst, j_jmp, j_br,
                    j_mrd, j_mwr, j_m2r, j_asrc, j_rwe, j_aop, j_ret};
    assign obs_n = {n_st, n_cause, n_trap, n_ireq, n_dreq, n_irw, n_pcw, n_rdst, n_jmp, n_br,
                    n_mrd, n_mwr, n_m2r, n_asrc, n_rwe, n_aop, n_ret};

    always @(posedge clk) begin
        if ((use_n ? n_ret : j_ret) === 1'b1) dut_ret <= dut_ret + 1;
    end

    function automatic logic [20:0] cur_obs();
        return use_n ? obs_n : obs_j;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", t, got, want);
        end
    endtask

    // 0 = illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BR, 6 JAL, 7 JALR
    function automatic int cls_of(input logic [6:0] op, input bit jalr_ok);
        case (op)
            OPC_R:     return 1;
            OPC_I:     return 2;
            OPC_LOAD:  return 3;
            OPC_STORE: return 4;
            OPC_BR:    return 5;
            OPC_JAL:   return 6;
            OPC_JALR:  return jalr_ok ? 7 : 0;
            default:   return 0;
        endcase
    endfunction

    task automatic push(input logic ir, input logic dr, input logic [2:0] st,
                        input logic [11:0] ctl, input logic [1:0] aop, input logic ret);
        step_t s;
        s.ir  = ir;
        s.dr  = dr;
        s.exp = {st, m_cause, (st == 3'd7), ctl, aop, ret};
        q.push_back(s);
    endtask

    task automatic trap_tail(input logic [1:0] cause);
        m_cause = cause;
        for (int k = 0; k < 3; k++) push(rb(), rb(), 3'd7, 12'h0, 2'b00, 1'b0);
    endtask

    // Expected cycle-by-cycle trace for one instruction with wi fetch waits and dw data waits.
    task automatic gen(input logic [6:0] op, input int wi, input int dw, input bit jalr_ok,
                       input bit abort_mem, output bit trapped);
        int c;
        logic [11:0] w;
        trapped = 1'b0;
        opcode  = op;
        c = cls_of(op, jalr_ok);
        for (int k = 0; k < wi && k < TMO; k++) push(1'b0, rb(), 3'd0, C_IREQ, 2'b00, 1'b0);
        if (wi >= TMO) begin trap_tail(2'd2); trapped = 1'b1; return; end
        push(1'b1, rb(), 3'd0, C_IREQ | C_IRW, 2'b00, 1'b0);
        push(rb(), rb(), 3'd1, 12'h0, 2'b00, 1'b0);
        if (c == 0) begin trap_tail(2'd1); trapped = 1'b1; return; end
        case (c)
            1:          push(rb(), rb(), 3'd2, 12'h0, 2'b00, 1'b0);
            2, 3, 4, 7: push(rb(), rb(), 3'd2, C_ASRC, 2'b01, 1'b0);
            5: begin
                push(rb(), rb(), 3'd2, C_BR | C_PCW, 2'b10, 1'b1);
                m_ret++;
                return;
            end
            default:    push(rb(), rb(), 3'd2, 12'h0, 2'b00, 1'b0);
        endcase
        if (c == 3 || c == 4) begin
            w = C_DREQ | C_ASRC | ((c == 3) ? C_MRD : C_MWR);
            for (int k = 0; k < dw && k < TMO; k++) push(rb(), 1'b0, 3'd3, w, 2'b01, 1'b0);
            if (abort_mem) return;
            if (dw >= TMO) begin trap_tail(2'd3); trapped = 1'b1; return; end
            if (c == 4) begin
                push(rb(), 1'b1, 3'd3, w | C_PCW, 2'b01, 1'b1);
                m_ret++;
                return;
            end
            push(rb(), 1'b1, 3'd3, w, 2'b01, 1'b0);
        end
        w = C_RWE | C_PCW | ((c == 1 || c == 6) ? C_RDST : 12'h0) |
            ((c == 3) ? C_M2R : 12'h0) | ((c == 6 || c == 7) ? C_JMP : 12'h0);
        push(rb(), rb(), 3'd4, w, 2'b00, 1'b1);
        m_ret++;
    endtask

    task automatic run();
        step_t s;
        int idx;
        idx = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            imem_ready = s.ir;
            dmem_ready = s.dr;
            @(negedge clk);
            chk($sformatf("%s/cyc%0d", tag, idx), 32'(cur_obs()), 32'(s.exp));
            @(posedge clk);
            #1;
            idx++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        if (use_n) rst_n_n = 1'b0; else rst_n_j = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/reset"}, 32'(cur_obs()), 32'h0);
        m_cause = 2'd0;
        @(posedge clk);
        #1;
        if (use_n) rst_n_n = 1'b1; else rst_n_j = 1'b1;
    endtask

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return OPC_R;
            1: return OPC_I;
            2: return OPC_LOAD;
            3: return OPC_STORE;
            4: return OPC_BR;
            5: return OPC_JAL;
            6: return OPC_LOAD;
            7: return OPC_JALR;
            8: return 7'($urandom_range(0, 127));
            default: return 7'h7f;
        endcase
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return r % 3;
        if (r < 8) return TMO - 1;
        return TMO;
    endfunction

    initial begin
        bit tr;
        rst_n_j = 1'b0;
        rst_n_n = 1'b0;
        opcode = 7'h0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        tag = "j_init"; do_reset();
        tag = "r_type";     gen(OPC_R, 0, 0, 1'b1, 1'b0, tr);     run();
        tag = "load_w3";    gen(OPC_LOAD, 0, 3, 1'b1, 1'b0, tr);  run();
        tag = "store";      gen(OPC_STORE, 0, 0, 1'b1, 1'b0, tr); run();
        tag = "branch";     gen(OPC_BR, 1, 0, 1'b1, 1'b0, tr);    run();
        tag = "i_type";     gen(OPC_I, 0, 0, 1'b1, 1'b0, tr);     run();
        tag = "jal";        gen(OPC_JAL, 2, 0, 1'b1, 1'b0, tr);   run();
        tag = "jalr";       gen(OPC_JALR, 0, 0, 1'b1, 1'b0, tr);  run();
        tag = "illegal_7f"; gen(7'h7f, 0, 0, 1'b1, 1'b0, tr);     run(); do_reset();
        tag = "imem_to";    gen(OPC_R, TMO, 0, 1'b1, 1'b0, tr);   run(); do_reset();
        tag = "imem_edge";  gen(OPC_R, TMO - 1, 0, 1'b1, 1'b0, tr); run();
        tag = "dmem_to";    gen(OPC_LOAD, 0, TMO, 1'b1, 1'b0, tr); run(); do_reset();
        tag = "dmem_edge";  gen(OPC_STORE, 0, TMO - 1, 1'b1, 1'b0, tr); run();
        tag = "abort";      gen(OPC_STORE, 1, 2, 1'b1, 1'b1, tr); run(); do_reset();
        tag = "after_abort"; gen(OPC_R, 0, 0, 1'b1, 1'b0, tr);    run();

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            int wi, dw;
            op = pick_op();
            wi = pick_wait();
            dw = pick_wait();
            tag = $sformatf("rnd%0d_op%b_w%0d_%0d", n, op, wi, dw);
            gen(op, wi, dw, 1'b1, 1'b0, tr);
            run();
            if (tr) do_reset();
        end

        rst_n_j = 1'b0;
        use_n = 1'b1;
        tag = "n_init";   do_reset();
        tag = "n_jalr";   gen(OPC_JALR, 0, 0, 1'b0, 1'b0, tr); run(); do_reset();
        tag = "n_jal";    gen(OPC_JAL, 0, 0, 1'b0, 1'b0, tr);  run();
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            int wi, dw;
            op = pick_op();
            wi = pick_wait();
            dw = pick_wait();
            tag = $sformatf("nrnd%0d_op%b_w%0d_%0d", n, op, wi, dw);
            gen(op, wi, dw, 1'b0, 1'b0, tr);
            run();
            if (tr) do_reset();
        end

        @(posedge clk);
        #1;
        chk("retired_total", 32'(dut_ret), 32'(m_ret));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
